// File: rtl/sample_request_master.sv
// ---------------------------------------------------------------------------
// sample_request_master
//
// Board-side initiator of the GPIO sample-request handshake that the core's
// audio loop services. Once per sample period it raises req_o and waits for
// the core to answer with gpio_valid_i plus a sample on gpio_data_i. The
// sample is captured and presented on sample_o with a one-cycle strobe. If
// the core does not answer in time, the previous sample is replayed. The
// current sample is also driven out as a PWM DAC signal on pwm_o.
//
// Ports
//   clk           in   1         system clock
//   reset         in   1         asynchronous, active-low reset
//   enable        in   1         1 = run sample ticks, 0 = force IDLE
//   req_o         out  1         request line to the core
//   gpio_valid_i  in   1         core "sample ready" strobe (asynchronous)
//   gpio_data_i   in   SAMPLE_W  sample from the core, stable while valid
//   sample_o      out  SAMPLE_W  last accepted or replayed sample
//   sample_stb_o  out  1         one-cycle pulse when sample_o updates
//   timeout_o     out  1         sticky flag for any timeout or overrun
//   missed_cnt_o  out  CNT_W     saturating count of timeouts + overruns
//   pwm_o         out  1         PWM output, duty = sample_o / 2**SAMPLE_W
// ---------------------------------------------------------------------------
module sample_request_master #(
  parameter int CLK_DIV  = 1134,
  parameter int SAMPLE_W = 8,
  parameter int TIMEOUT  = 512,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                req_o,
  input  logic                gpio_valid_i,
  input  logic [SAMPLE_W-1:0] gpio_data_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_stb_o,
  output logic                timeout_o,
  output logic [CNT_W-1:0]    missed_cnt_o,
  output logic                pwm_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SAMPLE_W-1:0] PC_MAX = {SAMPLE_W{1'b1}};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [DIV_W-1:0]    div;
  logic                tick;
  logic                vs_meta;
  logic                vs;
  logic [1:0]          state;
  logic [WD_W-1:0]     wdog;
  logic                capture;
  logic                timed_out;
  logic                overrun;
  logic                start_req;
  logic                miss_event;
  logic [SAMPLE_W-1:0] pc;
  logic [SAMPLE_W-1:0] duty;

  // Sample-period divider. Held at zero while disabled so that a
  // re-enable always waits one full period before the first request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (!enable) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign tick = enable && (div == DIV_LAST);

  // Two-stage synchronizer for the core's valid strobe. The data bus is
  // not synchronized; it is only looked at once vs is high, by which time
  // the core holds it stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_meta <= 1'b0;
      vs      <= 1'b0;
    end else begin
      vs_meta <= gpio_valid_i;
      vs      <= vs_meta;
    end
  end

  // Event decode. A valid response wins over the watchdog in the same
  // cycle. A tick outside IDLE, or in IDLE while valid is still high from
  // the previous transaction, is an overrun and the tick is dropped.
  always_comb begin
    capture   = 1'b0;
    timed_out = 1'b0;
    overrun   = 1'b0;
    start_req = 1'b0;
    if (enable) begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            if (vs) overrun = 1'b1;
            else    start_req = 1'b1;
          end
        end
        ST_REQ: begin
          if (vs)                   capture = 1'b1;
          else if (wdog == WD_LAST) timed_out = 1'b1;
          if (tick)                 overrun = 1'b1;
        end
        ST_RELEASE: begin
          if (tick) overrun = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A timeout and an overrun in the same cycle are a single miss.
  assign miss_event = timed_out | overrun;

  // Handshake FSM. Dropping enable abandons any transaction on the next
  // clock without capture, strobe or count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      req_o <= 1'b0;
      wdog  <= '0;
    end else if (!enable) begin
      state <= ST_IDLE;
      req_o <= 1'b0;
      wdog  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state <= ST_REQ;
            req_o <= 1'b1;
            wdog  <= '0;
          end
        end
        ST_REQ: begin
          if (capture || timed_out) begin
            state <= ST_RELEASE;
            req_o <= 1'b0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!vs) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          req_o <= 1'b0;
        end
      endcase
    end
  end

  // Sample register. On a timeout the old value is kept but the strobe
  // still fires so downstream logic sees a (replayed) sample every period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_o     <= '0;
      sample_stb_o <= 1'b0;
    end else begin
      sample_stb_o <= capture | timed_out;
      if (capture) sample_o <= gpio_data_i;
    end
  end

  // Sticky error flag and saturating miss counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_o    <= 1'b0;
      missed_cnt_o <= '0;
    end else if (miss_event) begin
      timeout_o <= 1'b1;
      if (missed_cnt_o != CNT_MAX) missed_cnt_o <= missed_cnt_o + CNT_W'(1);
    end
  end

  // PWM DAC. The duty register only reloads as the counter wraps, so a
  // sample arriving mid-period takes effect from the next period and the
  // high time of each period always equals one sample value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      duty  <= '0;
      pwm_o <= 1'b0;
    end else begin
      pc    <= pc + SAMPLE_W'(1);
      if (pc == PC_MAX) duty <= sample_o;
      pwm_o <= (pc < duty);
    end
  end

endmodule
